btn_debounce_evt: RTL and testbench
===================================

BTN_DEBOUNCE_EVT -- requirements
Module: btn_debounce_evt

Interface
REQ-001 SHALL have parameter N, default 4: number of independent button channels (1..32).
REQ-002 SHALL have parameter CN, default 240000: cycles a synchronised input must differ from the debounced level before that level changes (CN >= 2).
REQ-003 SHALL have parameter LN, default 24000000: cycles the debounced level must stay pressed before a long-press event (LN >= 2).
REQ-004 SHALL have parameter POL, default 0: active input level (0 = active-low push buttons, 1 = active-high).
REQ-005 SHALL have port clk, input, 1: system clock; one clock domain only.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port en_i, input, 1: when low, all counters hold and no event pulses are issued.
REQ-008 SHALL have port d_i, input, N: raw asynchronous button inputs.
REQ-009 SHALL have port d_o, output, N: debounced level, 1 = pressed, independent of POL.
REQ-010 SHALL have port press_o, output, N: one-cycle pulse on each debounced press.
REQ-011 SHALL have port release_o, output, N: one-cycle pulse on each debounced release.
REQ-012 SHALL have port long_o, output, N: one-cycle pulse once per press after LN pressed cycles.

Function
REQ-013 Each channel SHALL pass d_i through a 2-flop synchroniser, then normalise to s = 1 when the input equals POL.
REQ-014 Each channel SHALL keep a debounce counter of clog2(CN) bits that increments every enabled cycle where s != d_o and clears when s == d_o.
REQ-015 When the counter is CN-1 and s != d_o on an enabled edge, d_o SHALL take s and the counter SHALL clear on that edge.
REQ-016 The input-edge-to-d_o latency SHALL be exactly CN+2 cycles for a clean edge with en_i held high.
REQ-017 Any bounce back to s == d_o before the count completes SHALL restart the count from 0, so a glitch shorter than CN cycles never reaches d_o.
REQ-018 press_o/release_o SHALL be registered and high during the first cycle d_o shows the new level, and only in that cycle.
REQ-019 Each channel SHALL keep a hold counter of clog2(LN+1) bits that increments every enabled cycle with d_o = 1, saturates at LN, and clears when d_o = 0.
REQ-020 long_o SHALL pulse for exactly one cycle, on the edge where the hold counter goes from LN-1 to LN; it SHALL never repeat within one press.
REQ-021 A release in the same cycle the hold counter would reach LN SHALL produce release_o and no long_o.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-023 With en_i low, counters and d_o SHALL hold, synchroniser flops SHALL keep sampling, and all pulses SHALL be 0.

Reset
REQ-024 rst SHALL asynchronously force: synchroniser flops to the inactive level (~POL), all counters to 0, d_o, press_o, release_o and long_o to 0.
REQ-025 A button held during reset SHALL be reported as a fresh press CN+2 cycles after rst deasserts, with no release_o.
REQ-026 Reset asserted mid-count or mid-press SHALL discard all pending state and issue no event pulse.

Structure
REQ-027 clog2 and the counter-width calculations SHALL live in the shared project constants/function include, not locally.
REQ-028 The per-channel logic SHALL be one sub-module, btn_debounce_ch, instantiated N times by a generate loop; the top SHALL contain only parameter checks and the array.

Verification (N=2, CN=4, LN=10, POL=0)
REQ-029 Drive d_i[0] 1->0 clean -> d_o[0] rises exactly 6 cycles later, with press_o[0] high only in that cycle.
REQ-030 Drive d_i[0] low for 3 cycles, then high -> d_o[0], press_o[0] and release_o[0] stay 0.
REQ-031 Hold d_i[1] low for 30 cycles -> press_o[1] once, long_o[1] once, 10 cycles after d_o[1] rises; release_o[1] follows the release after 6 cycles.
REQ-032 Release d_i[1] so d_o[1] falls on the cycle the hold count would reach 10 -> release_o[1] only; no long_o.
REQ-033 Hold d_i[0] low through rst and deassert rst -> press_o[0] 6 cycles later; assert rst mid-count -> all outputs 0 at once.
REQ-034 Press both channels in the same cycle with en_i low for 3 cycles mid-count -> both press pulses occur together, delayed by 3 cycles.

Source files
------------

// File: rtl/btn_debounce_evt_pkg.sv
// btn_debounce_evt_pkg: shared width helpers and event kinds for the button debouncer.
package btn_debounce_evt_pkg;
    typedef enum logic [1:0] {EV_PRESS, EV_REL, EV_LONG} evt_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        return r;
    endfunction
    function automatic int cnt_w(input int cn);
        return clog2(cn);
    endfunction
    function automatic int hold_w(input int ln);
        return clog2(ln + 1);
    endfunction
endpackage

// File: rtl/btn_debounce_evt_ch.sv
// btn_debounce_ch: one button channel -- synchroniser, debounce counter, press/release/long events.
module btn_debounce_ch
    import btn_debounce_evt_pkg::*;
#(
    parameter int CN  = 240000,
    parameter int LN  = 24000000,
    parameter int POL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic d_i,
    output logic d_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    localparam int CW = cnt_w(CN);
    localparam int HW = hold_w(LN);
    localparam logic ACT = POL != 0;
    logic s1_q, s2_q, lvl_q, press_q, rel_q, long_q;
    logic lvl_d, press_d, rel_d, long_d, s, diff, done;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    always_comb begin
        s       = s2_q == ACT;
        diff    = s != lvl_q;
        done    = diff && cnt_q == CW'(CN - 1);
        cnt_d   = !en_i ? cnt_q : (diff && !done) ? cnt_q + 1'b1 : '0;
        lvl_d   = en_i && done ? s : lvl_q;
        press_d = en_i && done && s;
        rel_d   = en_i && done && !s;
        // a release landing on the saturating edge wins over the long event
        hold_d  = !en_i ? hold_q : (!lvl_q || rel_d) ? '0 : hold_q == HW'(LN) ? hold_q : hold_q + 1'b1;
        long_d  = en_i && lvl_q && !rel_d && hold_q == HW'(LN - 1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= ~ACT;
            s2_q    <= ~ACT;
            cnt_q   <= '0;
            hold_q  <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            s1_q    <= d_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end
    assign d_o       = lvl_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign long_o    = long_q;
endmodule

// File: rtl/btn_debounce_evt.sv
// btn_debounce_evt: N independent debounced buttons with press, release and long-press pulses.
module btn_debounce_evt #(
    parameter int N   = 4,
    parameter int CN  = 240000,
    parameter int LN  = 24000000,
    parameter int POL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] d_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o,
    output logic [N-1:0] long_o
);
    if (N < 1 || N > 32) begin : g_bad_n
        $error("btn_debounce_evt: N must be 1..32");
    end
    if (CN < 2 || LN < 2) begin : g_bad_cnt
        $error("btn_debounce_evt: CN and LN must be >= 2");
    end
    if (POL != 0 && POL != 1) begin : g_bad_pol
        $error("btn_debounce_evt: POL must be 0 or 1");
    end
    for (genvar i = 0; i < N; i++) begin : g_ch
        btn_debounce_ch #(.CN(CN), .LN(LN), .POL(POL)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en_i),
            .d_i       (d_i[i]),
            .d_o       (d_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i]),
            .long_o    (long_o[i])
        );
    end
endmodule

// File: tb/tb_btn_debounce_evt.sv
// tb_btn_debounce_evt: directed scoreboard bench for btn_debounce_evt (N=2, CN=4, LN=10, active-low).
module tb_btn_debounce_evt;
    import btn_debounce_evt_pkg::*;
    typedef struct {
        int   cyc;
        int   ch;
        evt_e kind;
    } ev_t;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1;
    logic [1:0] d = 2'b11;
    logic [1:0] d_o, press_o, release_o, long_o;
    logic [1:0] ep, er, el, exp_do = 2'b00;
    int cyc = 0, checks = 0, errors = 0;
    ev_t q[$];

    btn_debounce_evt #(.N(2), .CN(4), .LN(10), .POL(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en),
        .d_i       (d),
        .d_o       (d_o),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int ofs, input int ch, input evt_e kind);
        q.push_back('{cyc + ofs, ch, kind});
    endtask

    // expected d_o follows the expected press/release events and drops with reset
    always @(negedge clk) begin
        ep = '0;
        er = '0;
        el = '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].cyc == cyc) begin
                if (q[i].kind == EV_PRESS) ep[q[i].ch] = 1'b1;
                if (q[i].kind == EV_REL) er[q[i].ch] = 1'b1;
                if (q[i].kind == EV_LONG) el[q[i].ch] = 1'b1;
                q.delete(i);
            end
        exp_do = rst ? 2'b00 : (exp_do | ep) & ~er;
        chk("press", press_o, ep);
        chk("release", release_o, er);
        chk("long", long_o, el);
        chk("level", d_o, exp_do);
    end

    initial begin
        tick(3);
        chk("rst_level", d_o, 2'b00);
        chk("rst_pulses", press_o | release_o | long_o, 2'b00);
        rst = 1'b0;
        tick(3);
        // clean press, long press, release on channel 0
        d[0] = 1'b0;
        push(6, 0, EV_PRESS);
        push(16, 0, EV_LONG);
        tick(20);
        d[0] = 1'b1;
        push(6, 0, EV_REL);
        tick(10);
        // a CN-1 cycle glitch must be swallowed
        d[0] = 1'b0;
        tick(3);
        d[0] = 1'b1;
        tick(10);
        // 30-cycle hold on channel 1
        d[1] = 1'b0;
        push(6, 1, EV_PRESS);
        push(16, 1, EV_LONG);
        tick(30);
        d[1] = 1'b1;
        push(6, 1, EV_REL);
        tick(10);
        // release lands on the edge the hold count would reach LN
        d[1] = 1'b0;
        push(6, 1, EV_PRESS);
        tick(10);
        d[1] = 1'b1;
        push(6, 1, EV_REL);
        tick(12);
        // button held through reset, then reset mid-press and mid-count
        d[0] = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        push(6, 0, EV_PRESS);
        tick(8);
        rst = 1'b1;
        #1;
        chk("rst_now_level", d_o, 2'b00);
        chk("rst_now_pulses", press_o | release_o | long_o, 2'b00);
        tick(2);
        rst = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(2);
        d[0] = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        // simultaneous press with enable dropped for 3 cycles mid-count
        d = 2'b00;
        push(9, 0, EV_PRESS);
        push(9, 1, EV_PRESS);
        push(19, 0, EV_LONG);
        push(19, 1, EV_LONG);
        tick(3);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        tick(25);
        d = 2'b11;
        push(6, 0, EV_REL);
        push(6, 1, EV_REL);
        tick(12);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending events expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
